// File: rtl/master_data_source_if.sv
// Source-side handshake bundle: consumer request, word, and source busy flag.
interface master_data_source_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic [DATA_W-1:0] data;
  logic              busy;

  // master = the data source; slave = the consumer that raises req
  modport master (input req, output data, output busy);
  modport slave  (output req, input data, input busy);
endinterface

// File: rtl/master_data_source.sv
// Deterministic word source with programmable bursts and busy gaps.
// Define SRC_LFSR_DATA_EN to switch the word stream from increment to a Galois LFSR.
module master_data_source #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(32'h0000_0001),
  parameter int                BURST_LEN  = 4,
  parameter int                GAP_CYCLES = 2,
  parameter int                NUM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  master_data_source_if.master  bus,
  output logic                  o_done,
  output logic [15:0]           o_word_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [15:0] BURST_C    = 16'((BURST_LEN < 1) ? 1 : BURST_LEN);
  localparam logic [15:0] GAP_LAST_C = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0] NUM_C      = 16'(NUM_WORDS);

`ifdef SRC_LFSR_DATA_EN
  localparam logic [DATA_W-1:0] POLY      = DATA_W'(32'h8020_0003);
  // An all-zero LFSR state never leaves zero, so a zero seed is bumped to 1.
  localparam logic [DATA_W-1:0] SEED_LOAD = (SEED == '0) ? DATA_W'(1) : SEED;

  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] d);
    return d[0] ? ((d >> 1) ^ POLY) : (d >> 1);
  endfunction
`else
  localparam logic [DATA_W-1:0] SEED_LOAD = SEED;

  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] d);
    return d + DATA_W'(1);
  endfunction
`endif

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [15:0]       word_cnt_reg, word_cnt_next;
  logic [15:0]       burst_cnt_reg, burst_cnt_next;
  logic [15:0]       gap_cnt_reg, gap_cnt_next;
  logic              xfer;

  // busy_reg is low exactly when state_reg is SEND, so this matches req && !busy.
  assign xfer = bus.req && (state_reg == SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      data_reg      <= SEED;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
      word_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      word_cnt_reg  <= word_cnt_next;
      burst_cnt_reg <= burst_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    done_next      = done_reg;
    word_cnt_next  = word_cnt_reg;
    burst_cnt_next = burst_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (i_start) begin
          state_next     = SEND;
          data_next      = SEED_LOAD;
          done_next      = 1'b0;
          word_cnt_next  = '0;
          burst_cnt_next = '0;
          gap_cnt_next   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          word_cnt_next = word_cnt_reg + 16'd1;
          data_next     = next_word(data_reg);
          // Finishing the run wins over starting a gap on the same edge.
          if ((NUM_WORDS != 0) && (word_cnt_next == NUM_C)) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            if (burst_cnt_reg + 16'd1 == BURST_C) begin
              state_next     = GAP;
              burst_cnt_next = '0;
              gap_cnt_next   = '0;
            end else begin
              burst_cnt_next = burst_cnt_reg + 16'd1;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST_C) begin
          state_next   = SEND;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != SEND);
  end

  assign bus.data   = data_reg;
  assign bus.busy   = busy_reg;
  assign o_done     = done_reg;
  assign o_word_cnt = word_cnt_reg;

endmodule
